// File: rtl/tamagotchi_pkg.sv
// Shared constants for the pet controller: one-hot activity encoding (also used by the
// display/needs logic), command encoding and combo-resolver state constants.
package tamagotchi_pkg;

  localparam logic [3:0] EST_IDLE     = 4'b0000;
  localparam logic [3:0] EST_DORMINDO = 4'b0001;
  localparam logic [3:0] EST_COMENDO  = 4'b0010;
  localparam logic [3:0] EST_AULA     = 4'b0100;
  localparam logic [3:0] EST_MORTO    = 4'b1000;

  typedef enum logic [1:0] {
    CMD_NENHUM = 2'd0,
    CMD_B1     = 2'd1,
    CMD_B2     = 2'd2,
    CMD_COMBO  = 2'd3
  } cmd_t;

  localparam logic [1:0] RES_ESPERA    = 2'd0;
  localparam logic [1:0] RES_JANELA_B1 = 2'd1;
  localparam logic [1:0] RES_JANELA_B2 = 2'd2;

  // A limit of zero disables the timeout; tempo_inc is the count after this tick.
  function automatic logic estourou(input logic [31:0] tempo_inc, input int unsigned limite);
    return (limite != 0) && (tempo_inc >= limite);
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Button conditioner: 2-FF synchroniser, counter-based debounce and a one-cycle pulse on
// the debounced rising edge.
module filtro_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic pulso
);

  localparam int unsigned W_CNT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [W_CNT-1:0] CNT_FIM = W_CNT'(DEBOUNCE_CICLOS - 1);
  localparam logic [W_CNT-1:0] CNT_UM  = 1;

  logic [1:0]       sync_q, sync_d;
  logic             nivel_q, nivel_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             pulso_q, pulso_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sync_d  = {sync_q[0], botao};
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (sync_q[1] != nivel_q) begin
      if (cnt_q == CNT_FIM) nivel_d = sync_q[1];
      else                  cnt_d   = cnt_q + CNT_UM;
    end
    pulso_d = nivel_d & ~nivel_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      nivel_q <= 1'b0;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/controlador_atividades.sv
// Activity controller: filters b1/b2, resolves single/combo commands and runs the activity
// FSM with per-state timeouts. Define REVIVER_EN to allow a combo to leave MORTO.
module controlador_atividades
  import tamagotchi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS    = 16,
  parameter int unsigned JANELA_COMBO       = 8,
  parameter int unsigned TEMPO_MAX_COMENDO  = 10,
  parameter int unsigned TEMPO_MAX_DORMINDO = 30,
  parameter int unsigned TEMPO_MAX_AULA     = 20,
  parameter int unsigned W_TEMPO            = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               b1,
  input  logic               b2,
  input  logic               morreu,
  output logic [3:0]         estado,
  output logic               mudou,
  output logic [W_TEMPO-1:0] tempo_estado
);

  localparam int unsigned W_JAN = (JANELA_COMBO > 0) ? $clog2(JANELA_COMBO + 1) : 1;
  localparam logic [W_JAN-1:0]   JAN_FIM  = W_JAN'(JANELA_COMBO);
  localparam logic [W_JAN-1:0]   JAN_UM   = 1;
  localparam logic [W_TEMPO-1:0] TEMPO_UM = 1;

  // Reset asserts asynchronously but is released two edges later, in step with clk.
  logic [1:0] rst_sinc_q, rst_sinc_d;
  logic       rst_int_n;

  assign rst_sinc_d = {rst_sinc_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sinc_q <= '0;
    else        rst_sinc_q <= rst_sinc_d;
  end

  assign rst_int_n = rst_sinc_q[1];

  logic p1, p2;

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_b1 (
    .clk   (clk),
    .rst_n (rst_int_n),
    .botao (b1),
    .pulso (p1)
  );

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_b2 (
    .clk   (clk),
    .rst_n (rst_int_n),
    .botao (b2),
    .pulso (p2)
  );

  // Combo resolver
  logic [1:0]       res_q, res_d;
  logic [W_JAN-1:0] jan_q, jan_d;
  cmd_t             cmd_q, cmd_d;

  always_comb begin
    res_d = res_q;
    jan_d = jan_q;
    cmd_d = CMD_NENHUM;
    case (res_q)
      RES_ESPERA: begin
        if (p1 && p2) begin
          cmd_d = CMD_COMBO;
        end else if (p1) begin
          if (JANELA_COMBO == 0) cmd_d = CMD_B1;
          else begin
            res_d = RES_JANELA_B1;
            jan_d = JAN_UM;
          end
        end else if (p2) begin
          if (JANELA_COMBO == 0) cmd_d = CMD_B2;
          else begin
            res_d = RES_JANELA_B2;
            jan_d = JAN_UM;
          end
        end
      end
      RES_JANELA_B1: begin
        if (p2) begin
          cmd_d = CMD_COMBO;
          res_d = RES_ESPERA;
        end else if (jan_q == JAN_FIM) begin
          cmd_d = CMD_B1;
          res_d = RES_ESPERA;
        end else begin
          jan_d = jan_q + JAN_UM;
        end
      end
      RES_JANELA_B2: begin
        if (p1) begin
          cmd_d = CMD_COMBO;
          res_d = RES_ESPERA;
        end else if (jan_q == JAN_FIM) begin
          cmd_d = CMD_B2;
          res_d = RES_ESPERA;
        end else begin
          jan_d = jan_q + JAN_UM;
        end
      end
      default: res_d = RES_ESPERA;
    endcase
  end

  // Activity FSM
  logic [3:0]         estado_q, estado_d;
  logic               mudou_q, mudou_d;
  logic [W_TEMPO-1:0] tempo_q, tempo_d;
  logic [31:0]        tempo_inc;
  logic               expira_comendo, expira_dormindo, expira_aula;

  assign tempo_inc       = 32'(tempo_q) + 32'd1;
  assign expira_comendo  = tick && estourou(tempo_inc, TEMPO_MAX_COMENDO);
  assign expira_dormindo = tick && estourou(tempo_inc, TEMPO_MAX_DORMINDO);
  assign expira_aula     = tick && estourou(tempo_inc, TEMPO_MAX_AULA);

  always_comb begin
    estado_d = estado_q;
    if (morreu) begin
      estado_d = EST_MORTO;
    end else begin
      case (estado_q)
        EST_IDLE: begin
          case (cmd_q)
            CMD_B1:    estado_d = EST_COMENDO;
            CMD_B2:    estado_d = EST_DORMINDO;
            CMD_COMBO: estado_d = EST_AULA;
            default:   estado_d = EST_IDLE;
          endcase
        end
        EST_COMENDO:  if (cmd_q == CMD_B1    || expira_comendo)  estado_d = EST_IDLE;
        EST_DORMINDO: if (cmd_q == CMD_B2    || expira_dormindo) estado_d = EST_IDLE;
        EST_AULA:     if (cmd_q == CMD_COMBO || expira_aula)     estado_d = EST_IDLE;
        EST_MORTO: begin
`ifdef REVIVER_EN
          if (cmd_q == CMD_COMBO) estado_d = EST_IDLE;
`else
          estado_d = EST_MORTO;
`endif
        end
        default: estado_d = EST_IDLE;
      endcase
    end

    mudou_d = (estado_d != estado_q);
    if (mudou_d)                    tempo_d = '0;
    else if (tick && tempo_q != '1) tempo_d = tempo_q + TEMPO_UM;
    else                            tempo_d = tempo_q;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      res_q    <= RES_ESPERA;
      jan_q    <= '0;
      cmd_q    <= CMD_NENHUM;
      estado_q <= EST_IDLE;
      mudou_q  <= 1'b0;
      tempo_q  <= '0;
    end else begin
      res_q    <= res_d;
      jan_q    <= jan_d;
      cmd_q    <= cmd_d;
      estado_q <= estado_d;
      mudou_q  <= mudou_d;
      tempo_q  <= tempo_d;
    end
  end

  assign estado       = estado_q;
  assign mudou        = mudou_q;
  assign tempo_estado = tempo_q;

endmodule

// File: tb/tb_controlador_atividades.sv
// Bench for controlador_atividades: expected state changes are queued as stimulus is
// driven and popped whenever the DUT pulses mudou.
module tb_controlador_atividades;

  localparam logic [3:0] E_IDLE     = 4'b0000;
  localparam logic [3:0] E_DORMINDO = 4'b0001;
  localparam logic [3:0] E_COMENDO  = 4'b0010;
  localparam logic [3:0] E_AULA     = 4'b0100;
  localparam logic [3:0] E_MORTO    = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       b1 = 1'b0;
  logic       b2 = 1'b0;
  logic       morreu = 1'b0;
  logic [3:0] estado;
  logic       mudou;
  logic [7:0] tempo_estado;

  int n_testes = 0;
  int n_falhas = 0;

  logic [3:0] fila_esperado[$];
  logic [3:0] esperado_mon;

  controlador_atividades #(
    .DEBOUNCE_CICLOS    (4),
    .JANELA_COMBO       (8),
    .TEMPO_MAX_COMENDO  (3),
    .TEMPO_MAX_DORMINDO (0),
    .TEMPO_MAX_AULA     (0),
    .W_TEMPO            (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .b1           (b1),
    .b2           (b2),
    .morreu       (morreu),
    .estado       (estado),
    .mudou        (mudou),
    .tempo_estado (tempo_estado)
  );

  always #5 clk = ~clk;

  // Scoreboard: every mudou pulse must match the next queued state.
  always @(negedge clk) begin
    if (rst_n && mudou) begin
      n_testes++;
      if (fila_esperado.size() == 0) begin
        n_falhas++;
        $display("FAIL mudou_inesperado: estado=%b, nenhuma mudanca esperada", estado);
      end else begin
        esperado_mon = fila_esperado.pop_front();
        if (estado !== esperado_mon) begin
          n_falhas++;
          $display("FAIL mudou_estado: estado=%b esperado=%b", estado, esperado_mon);
        end
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; b1 = 1'b0; b2 = 1'b0; tick = 1'b0; morreu = 1'b0;
    ciclos(2);
    rst_n = 1'b1;
    ciclos(5);
  endtask

  task automatic pressiona(input logic v1, input logic v2, input int hold);
    b1 = v1; b2 = v2;
    ciclos(hold);
    b1 = 1'b0; b2 = 1'b0;
  endtask

  task automatic espera_estado(input logic [3:0] alvo, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (estado === alvo) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fim_cenario(input string nome, input logic [3:0] alvo);
    ciclos(40);
    n_testes++;
    if (estado !== alvo) begin
      n_falhas++;
      $display("FAIL %s_estado: estado=%b esperado=%b", nome, estado, alvo);
    end
    n_testes++;
    if (fila_esperado.size() != 0) begin
      n_falhas++;
      $display("FAIL %s_pendentes: %0d mudancas nao ocorreram, esperado 0", nome, fila_esperado.size());
      fila_esperado.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_testes++;
    if (estado !== E_IDLE) begin
      n_falhas++; $display("FAIL reset_estado: estado=%b esperado=%b", estado, E_IDLE);
    end
    n_testes++;
    if (mudou !== 1'b0) begin
      n_falhas++; $display("FAIL reset_mudou: mudou=%b esperado=0", mudou);
    end
    n_testes++;
    if (tempo_estado !== 8'd0) begin
      n_falhas++; $display("FAIL reset_tempo: tempo=%0d esperado=0", tempo_estado);
    end
    do_reset();
  endtask

  task automatic test_botao_segurado();
    do_reset();
    fila_esperado.push_back(E_COMENDO);
    pressiona(1'b1, 1'b0, 50);
    fim_cenario("segurado", E_COMENDO);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b1 = ~b1;
      ciclos(2);
    end
    b1 = 1'b0;
    fim_cenario("bounce", E_IDLE);
  endtask

  task automatic test_combo();
    do_reset();
    fila_esperado.push_back(E_AULA);
    b1 = 1'b1; ciclos(5);
    b2 = 1'b1; ciclos(10);
    b1 = 1'b0; b2 = 1'b0;
    fim_cenario("combo_gap5", E_AULA);

    do_reset();
    fila_esperado.push_back(E_COMENDO);
    pressiona(1'b1, 1'b0, 10);
    ciclos(2);
    pressiona(1'b0, 1'b1, 10);
    ciclos(20);
    fim_cenario("combo_gap12", E_COMENDO);
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    fila_esperado.push_back(E_COMENDO);
    b1 = 1'b1;
    espera_estado(E_COMENDO, 40, ok);
    b1 = 1'b0;
    n_testes++;
    if (!ok) begin
      n_falhas++; $display("FAIL timeout_entra_comendo: estado=%b esperado=%b", estado, E_COMENDO);
    end
    n_testes++;
    if (tempo_estado !== 8'd0) begin
      n_falhas++; $display("FAIL timeout_tempo_entrada: tempo=%0d esperado=0", tempo_estado);
    end
    ciclos(20);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) fila_esperado.push_back(E_IDLE);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n_testes++;
      if (i < 3 && (estado !== E_COMENDO || tempo_estado !== 8'(i))) begin
        n_falhas++;
        $display("FAIL timeout_tick%0d: estado=%b tempo=%0d esperado estado=%b tempo=%0d",
                 i, estado, tempo_estado, E_COMENDO, i);
      end else if (i == 3 && (estado !== E_IDLE || tempo_estado !== 8'd0)) begin
        n_falhas++;
        $display("FAIL timeout_tick3: estado=%b tempo=%0d esperado estado=%b tempo=0",
                 estado, tempo_estado, E_IDLE);
      end
    end
    fim_cenario("timeout_comendo", E_IDLE);

    do_reset();
    fila_esperado.push_back(E_DORMINDO);
    b2 = 1'b1;
    espera_estado(E_DORMINDO, 40, ok);
    b2 = 1'b0;
    n_testes++;
    if (!ok) begin
      n_falhas++; $display("FAIL saturacao_entra_dormindo: estado=%b esperado=%b", estado, E_DORMINDO);
    end
    ciclos(20);
    for (int i = 1; i <= 300; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (i == 100 || i == 255 || i == 300) begin
        n_testes++;
        if (tempo_estado !== 8'((i > 255) ? 255 : i)) begin
          n_falhas++;
          $display("FAIL saturacao_tick%0d: tempo=%0d esperado=%0d", i, tempo_estado,
                   (i > 255) ? 255 : i);
        end
      end
    end
    fim_cenario("saturacao", E_DORMINDO);
  endtask

  task automatic test_morreu();
    bit ok;
    do_reset();
    fila_esperado.push_back(E_DORMINDO);
    b2 = 1'b1;
    espera_estado(E_DORMINDO, 40, ok);
    b2 = 1'b0;
    n_testes++;
    if (!ok) begin
      n_falhas++; $display("FAIL morreu_entra_dormindo: estado=%b esperado=%b", estado, E_DORMINDO);
    end
    ciclos(20);
    pressiona(1'b1, 1'b0, 10);
    fila_esperado.push_back(E_MORTO);
    morreu = 1'b1;
    @(negedge clk);
    morreu = 1'b0;
    n_testes++;
    if (estado !== E_MORTO) begin
      n_falhas++; $display("FAIL morreu_latencia: estado=%b esperado=%b", estado, E_MORTO);
    end
    fim_cenario("morreu_pegajoso", E_MORTO);
`ifdef REVIVER_EN
    fila_esperado.push_back(E_IDLE);
    pressiona(1'b1, 1'b1, 10);
    fim_cenario("reviver", E_IDLE);
`else
    pressiona(1'b1, 1'b1, 10);
    fim_cenario("reviver", E_MORTO);
`endif
  endtask

  task automatic test_reset_janela();
    bit ok;
    do_reset();
    fila_esperado.push_back(E_COMENDO);
    b1 = 1'b1;
    espera_estado(E_COMENDO, 40, ok);
    b1 = 1'b0;
    n_testes++;
    if (!ok) begin
      n_falhas++; $display("FAIL rst_janela_entra: estado=%b esperado=%b", estado, E_COMENDO);
    end
    ciclos(20);
    pressiona(1'b1, 1'b0, 8);
    ciclos(2);
    rst_n = 1'b0;
    #1;
    n_testes++;
    if (estado !== E_IDLE || tempo_estado !== 8'd0 || mudou !== 1'b0) begin
      n_falhas++;
      $display("FAIL rst_janela_async: estado=%b tempo=%0d mudou=%b esperado %b/0/0",
               estado, tempo_estado, mudou, E_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fim_cenario("rst_janela", E_IDLE);
  endtask

  initial begin
    test_reset();
    test_botao_segurado();
    test_bounce();
    test_combo();
    test_timeout();
    test_morreu();
    test_reset_janela();
    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
